mcu_stripe_reader: RTL and testbench
====================================

Name: mcu_stripe_reader

Overview:
- Read side of the double-buffered EBR pixel store filled by the camera ingester.
- When the ingester completes an 8-row stripe and flips its front-buffer select, this block reads that finished half back out, one 8x8 MCU at a time, in MCU order.
- Delivers one pixel per beat over a valid/ready stream to the JPEG transform pipeline.
- Sits between the EBR bank read ports and the DCT input.

Parameters:
- width_pix, 320, frame width in pixels; multiple of 8.
- height_pix, 240, frame height in pixels; multiple of 8; stripes per frame = height_pix/8.
- num_ebr, 5, number of EBRs per buffer half; MCU m lives in EBR (m mod num_ebr).
- ebr_size, 512, words per EBR half; address = {m / num_ebr, py, px}.

Ports:
- clock  in  1  system clock; single clock domain.
- nreset  in  1  asynchronous, active-low reset.
- frontbuffer_select  in  1  ingester's current write half; every toggle means the other half holds a complete stripe.
- rd_block_select  out  $clog2(num_ebr)  EBR index to read.
- rd_buffer_select  out  1  buffer half to read; always the half not being written.
- rd_addr  out  $clog2(ebr_size)  EBR word address.
- rd_en  out  1  read strobe; data returns exactly 1 cycle later.
- rd_data  in  8  muxed EBR read data, valid the cycle after rd_en.
- pix_data  out  8  output pixel.
- pix_valid  out  1  pix_data valid.
- pix_ready  in  1  downstream accepts when pix_valid && pix_ready.
- mcu_first  out  1  qualifies first pixel of an MCU.
- mcu_last  out  1  qualifies 64th pixel of an MCU.
- frame_last  out  1  qualifies final pixel of final MCU of final stripe.
- overrun  out  1  sticky: a stripe was lost.

Behaviour:
- Reset (async, nreset=0):
  - Outputs: rd_en=0, pix_valid=0, overrun=0; rd_block_select, rd_addr, rd_buffer_select, mcu_first, mcu_last and frame_last all 0.
  - Internal: FIFO empty, pending=0, stripe counter 0, state IDLE.
  - frontbuffer_select is sampled into fb_prev on the first clock after release. No toggle is inferred at release.
- Toggle detect: frontbuffer_select != fb_prev sets pending=1 and latches rd_buffer_select = fb_prev (the just-completed half).
- Overrun: a toggle while pending=1, or while READ/DRAIN is in progress, sets overrun=1. It is sticky until reset.
  - If the toggle arrives in READ or DRAIN, the current stripe finishes unaltered and pending is set for the new stripe.
- States:
  - IDLE: if pending, clear pending, zero the counters, go to READ.
  - READ: issue reads; after the address of pixel 63 of MCU width_pix/8-1 is issued, go to DRAIN.
  - DRAIN: when the FIFO is empty and no read is in flight, go to READ if pending (clear it), else IDLE.
- Address sequence, innermost first:
  - px 0..7, then py 0..7: raster order within the MCU.
  - Then rd_block_select 0..num_ebr-1 (wrap).
  - Then mcu_div increments on block wrap.
  - mcux counts 0..width_pix/8-1 in parallel with the MCU sequence.
  - Defaults: 40 MCUs, 2560 reads per stripe.
- Flow control:
  - 2-entry output FIFO.
  - rd_en is asserted only when (FIFO occupancy + reads in flight) < 2.
  - No pixel is dropped or duplicated under any pix_ready pattern.
  - Sustained throughput is 1 pixel/clock when pix_ready is held 1.
- Output data: pix_data = rd_data unmodified; the level shift was already applied on ingest.
- Flags: mcu_first, mcu_last and frame_last travel through the FIFO alongside their pixel.
- Stripe counter: increments at end of stripe and wraps at height_pix/8-1. frame_last is asserted on the last pixel of stripe height_pix/8-1.
- Latency:
  - First rd_en: 2 cycles after the toggle edge (sample, IDLE->READ).
  - First pix_valid: 2 cycles after that first rd_en (EBR latency plus FIFO register).

Optional Feature:
- Macro: MCU_READER_TRANSPOSE_EN.
- Defined: within each MCU, py is the fastest counter and px the outer counter (column-major), so the column-pass DCT is fed directly. mcu_first and mcu_last still mark the 1st and 64th pixel emitted.
- Undefined: raster order, px fastest.

Test Plan:
- Reset release with frontbuffer_select=1, no toggle -> pix_valid and rd_en stay 0 for 100 cycles; overrun=0.
- Toggle 0->1 with EBR model preloaded so word = (block*64 + addr)&0xFF, pix_ready=1:
  - Exactly 2560 beats with rd_buffer_select=0.
  - Beat 0 is block0/addr0; beat 64 is block1/addr0; beat 320 is block0/addr64.
  - mcu_last on beats 63, 127, ..., 2559.
- Same stream with pix_ready toggled pseudo-randomly at 50% -> identical beat sequence; no loss or duplication; pix_data stable while valid && !ready.
- Second toggle issued 1000 cycles into a stripe with pix_ready=0 -> overrun=1; current stripe completes all 2560 beats; the following stripe reads half 1.
- 30 back-to-back stripes -> frame_last exactly once, on beat 2559 of stripe 29; stripe counter back to 0.
- With MCU_READER_TRANSPOSE_EN defined -> beat 1 reads addr 8 and beat 8 reads addr 1 in MCU 0.

Source files
------------

// File: rtl/mcu_stripe_reader.sv
// mcu_stripe_reader: read side of the double-buffered EBR pixel store.
// When the ingester flips its front-buffer select, the half it just finished
// is read back one 8x8 MCU at a time and streamed out, one pixel per beat.
// Build option: define MCU_READER_TRANSPOSE_EN to emit each MCU column-major
// (py fastest) instead of raster order (px fastest).
`timescale 1ns/1ps

module mcu_stripe_reader #(
    parameter int width_pix  = 320,
    parameter int height_pix = 240,
    parameter int num_ebr    = 5,
    parameter int ebr_size   = 512,
    localparam int blk_w     = (num_ebr > 1) ? $clog2(num_ebr) : 1,
    localparam int addr_w    = $clog2(ebr_size)
) (
    input  logic              clock,
    input  logic              nreset,
    input  logic              frontbuffer_select,
    output logic [blk_w-1:0]  rd_block_select,
    output logic              rd_buffer_select,
    output logic [addr_w-1:0] rd_addr,
    output logic              rd_en,
    input  logic [7:0]        rd_data,
    output logic [7:0]        pix_data,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic              mcu_first,
    output logic              mcu_last,
    output logic              frame_last,
    output logic              overrun
);

    localparam int mcus_x   = width_pix / 8;
    localparam int stripes  = height_pix / 8;
    localparam int mcux_w   = (mcus_x > 1) ? $clog2(mcus_x) : 1;
    localparam int stripe_w = (stripes > 1) ? $clog2(stripes) : 1;
    localparam int div_w    = addr_w - 6;

    localparam logic [blk_w-1:0]    blk_last    = blk_w'(num_ebr - 1);
    localparam logic [mcux_w-1:0]   mcux_last   = mcux_w'(mcus_x - 1);
    localparam logic [stripe_w-1:0] stripe_last = stripe_w'(stripes - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_DRAIN
    } state_t;

    // One output-FIFO slot: the pixel plus the flags that travel with it.
    typedef struct packed {
        logic       frame_last;
        logic       last;
        logic       first;
        logic [7:0] data;
    } fifo_entry_t;

    state_t                state_q, state_d;
    logic                  fb_prev_q, fb_prev_d;
    logic                  fb_init_q, fb_init_d;
    logic                  pending_q, pending_d;
    logic                  pending_half_q, pending_half_d;
    logic                  overrun_q, overrun_d;
    logic                  rd_buffer_select_q, rd_buffer_select_d;
    logic [2:0]            inner_q, inner_d;
    logic [2:0]            outer_q, outer_d;
    logic [blk_w-1:0]      blk_q, blk_d;
    logic [div_w-1:0]      div_q, div_d;
    logic [mcux_w-1:0]     mcux_q, mcux_d;
    logic [stripe_w-1:0]   stripe_q, stripe_d;
    logic                  rd_valid_q, rd_valid_d;
    logic [2:0]            rd_flags_q, rd_flags_d;
    fifo_entry_t           fifo_q [2];
    fifo_entry_t           fifo_d [2];
    logic                  wr_ptr_q, wr_ptr_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic [1:0]            count_q, count_d;

    logic                  toggle;
    logic                  pop;
    logic [2:0]            occ;
    logic                  first_c, last_c, stripe_end_c, frame_last_c;
    logic [2:0]            px, py;
    fifo_entry_t           head;

    // Inner counter is the fastest-moving coordinate inside the MCU.
`ifdef MCU_READER_TRANSPOSE_EN
    assign py = inner_q;
    assign px = outer_q;
`else
    assign px = inner_q;
    assign py = outer_q;
`endif

    // A flip is only meaningful once fb_prev holds a real sample.
    assign toggle = fb_init_q && (frontbuffer_select != fb_prev_q);

    assign pix_valid = (count_q != 2'd0);
    assign pop       = pix_valid && pix_ready;

    // Slots committed after this cycle: stored pixels minus the one leaving,
    // plus the read whose data is on rd_data now. Counting the pop lets a
    // new read issue every clock while the consumer keeps up.
    assign occ   = {1'b0, count_q} + {2'b00, rd_valid_q} - {2'b00, pop};
    assign rd_en = (state_q == ST_READ) && (occ < 3'd2);

    assign first_c      = (inner_q == 3'd0) && (outer_q == 3'd0);
    assign last_c       = (inner_q == 3'd7) && (outer_q == 3'd7);
    assign stripe_end_c = last_c && (mcux_q == mcux_last);
    assign frame_last_c = stripe_end_c && (stripe_q == stripe_last);

    assign rd_addr          = {div_q, py, px};
    assign rd_block_select  = blk_q;
    assign rd_buffer_select = rd_buffer_select_q;
    assign overrun          = overrun_q;

    assign head       = fifo_q[rd_ptr_q];
    assign pix_data   = head.data;
    assign mcu_first  = pix_valid && head.first;
    assign mcu_last   = pix_valid && head.last;
    assign frame_last = pix_valid && head.frame_last;

    // Next-state for the stripe FSM, MCU address counters and flip tracking.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one
        // unassigned; that is what keeps this block from inferring latches.
        state_d            = state_q;
        fb_prev_d          = frontbuffer_select;
        fb_init_d          = 1'b1;
        pending_d          = pending_q;
        pending_half_d     = pending_half_q;
        overrun_d          = overrun_q;
        rd_buffer_select_d = rd_buffer_select_q;
        inner_d            = inner_q;
        outer_d            = outer_q;
        blk_d              = blk_q;
        div_d              = div_q;
        mcux_d             = mcux_q;
        stripe_d           = stripe_q;
        rd_valid_d         = rd_en;
        rd_flags_d         = {frame_last_c, last_c, first_c};

        unique case (state_q)
            ST_IDLE: begin
                if (pending_q) begin
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                if (rd_en) begin
                    if (inner_q == 3'd7) begin
                        inner_d = 3'd0;
                        if (outer_q == 3'd7) begin
                            outer_d = 3'd0;
                            mcux_d  = mcux_q + mcux_w'(1);
                            if (blk_q == blk_last) begin
                                blk_d = '0;
                                div_d = div_q + div_w'(1);
                            end else begin
                                blk_d = blk_q + blk_w'(1);
                            end
                        end else begin
                            outer_d = outer_q + 3'd1;
                        end
                    end else begin
                        inner_d = inner_q + 3'd1;
                    end
                    if (stripe_end_c) begin
                        state_d  = ST_DRAIN;
                        stripe_d = (stripe_q == stripe_last) ? '0 : stripe_q + stripe_w'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if ((count_q == 2'd0) && !rd_valid_q) begin
                    state_d = pending_q ? ST_READ : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Starting a stripe: consume the pending flip and rewind the counters.
        if ((state_q != ST_READ) && (state_d == ST_READ)) begin
            pending_d          = 1'b0;
            rd_buffer_select_d = pending_half_q;
            inner_d            = '0;
            outer_d            = '0;
            blk_d              = '0;
            div_d              = '0;
            mcux_d             = '0;
        end

        // A flip on top of unread or in-progress work means a stripe is lost;
        // the running stripe finishes and the newest half is queued.
        if (toggle) begin
            pending_d      = 1'b1;
            pending_half_d = fb_prev_q;
            if (pending_q || (state_q != ST_IDLE)) begin
                overrun_d = 1'b1;
            end
        end
    end

    // Output FIFO bookkeeping: capture returning read data, release on handshake.
    always_comb begin
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (rd_valid_q) begin
            fifo_d[wr_ptr_q] = '{frame_last: rd_flags_q[2], last: rd_flags_q[1],
                                 first: rd_flags_q[0], data: rd_data};
            wr_ptr_d = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        if (rd_valid_q && !pop) begin
            count_d = count_q + 2'd1;
        end else if (!rd_valid_q && pop) begin
            count_d = count_q - 2'd1;
        end
    end

    // State register bank.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            // NOTE: the two FIFO slots are reset too; they are plain flops,
            // and it keeps pix_data defined from the first cycle.
            state_q            <= ST_IDLE;
            fb_prev_q          <= 1'b0;
            fb_init_q          <= 1'b0;
            pending_q          <= 1'b0;
            pending_half_q     <= 1'b0;
            overrun_q          <= 1'b0;
            rd_buffer_select_q <= 1'b0;
            inner_q            <= '0;
            outer_q            <= '0;
            blk_q              <= '0;
            div_q              <= '0;
            mcux_q             <= '0;
            stripe_q           <= '0;
            rd_valid_q         <= 1'b0;
            rd_flags_q         <= '0;
            fifo_q             <= '{default: '0};
            wr_ptr_q           <= 1'b0;
            rd_ptr_q           <= 1'b0;
            count_q            <= 2'd0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values, independent of statement order.
            state_q            <= state_d;
            fb_prev_q          <= fb_prev_d;
            fb_init_q          <= fb_init_d;
            pending_q          <= pending_d;
            pending_half_q     <= pending_half_d;
            overrun_q          <= overrun_d;
            rd_buffer_select_q <= rd_buffer_select_d;
            inner_q            <= inner_d;
            outer_q            <= outer_d;
            blk_q              <= blk_d;
            div_q              <= div_d;
            mcux_q             <= mcux_d;
            stripe_q           <= stripe_d;
            rd_valid_q         <= rd_valid_d;
            rd_flags_q         <= rd_flags_d;
            fifo_q             <= fifo_d;
            wr_ptr_q           <= wr_ptr_d;
            rd_ptr_q           <= rd_ptr_d;
            count_q            <= count_d;
        end
    end

endmodule

// File: tb/tb_mcu_stripe_reader.sv
// tb_mcu_stripe_reader: drives a full 30-stripe frame through the reader
// against an EBR model, comparing every read request and every delivered
// beat with a reference derived from MCU/pixel arithmetic.
`timescale 1ns/1ps

module tb_mcu_stripe_reader;

    localparam int W       = 320;
    localparam int H       = 240;
    localparam int NE      = 5;
    localparam int BEATS   = (W / 8) * 64;
    localparam int STRIPES = H / 8;

    logic       clock = 1'b0;
    logic       nreset;
    logic       frontbuffer_select;
    logic [2:0] rd_block_select;
    logic       rd_buffer_select;
    logic [8:0] rd_addr;
    logic       rd_en;
    logic [7:0] rd_data = 8'd0;
    logic [7:0] pix_data;
    logic       pix_valid;
    logic       pix_ready;
    logic       mcu_first;
    logic       mcu_last;
    logic       frame_last;
    logic       overrun;

    always #5 clock = ~clock;

    mcu_stripe_reader dut (
        .clock              (clock),
        .nreset             (nreset),
        .frontbuffer_select (frontbuffer_select),
        .rd_block_select    (rd_block_select),
        .rd_buffer_select   (rd_buffer_select),
        .rd_addr            (rd_addr),
        .rd_en              (rd_en),
        .rd_data            (rd_data),
        .pix_data           (pix_data),
        .pix_valid          (pix_valid),
        .pix_ready          (pix_ready),
        .mcu_first          (mcu_first),
        .mcu_last           (mcu_last),
        .frame_last         (frame_last),
        .overrun            (overrun)
    );

    // EBR model: one-cycle read latency, word = (block*64 + addr) & 0xFF.
    always @(posedge clock) begin
        if (rd_en) rd_data <= 8'((32'(rd_block_select) * 64 + 32'(rd_addr)) & 255);
    end

    int compared   = 0;
    int mismatched = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Read r of a stripe -> {half, block, addr}. Stripes here alternate halves
    // starting with half 0, because every flip in this run alternates the select.
    function automatic logic [12:0] model_read(input int stripe, input int r);
        int mcu, w, px, py, blk, addr;
        mcu = r / 64;
        w   = r % 64;
`ifdef MCU_READER_TRANSPOSE_EN
        px = w / 8;
        py = w % 8;
`else
        py = w / 8;
        px = w % 8;
`endif
        blk  = mcu % NE;
        addr = (mcu / NE) * 64 + py * 8 + px;
        return {1'(stripe % 2), 3'(blk), 9'(addr)};
    endfunction

    // Beat k of a stripe -> {frame_last, mcu_last, mcu_first, pixel}.
    function automatic logic [10:0] model_beat(input int stripe, input int k);
        logic [12:0] rd;
        int          data;
        rd   = model_read(stripe, k);
        data = (int'(rd[11:9]) * 64 + int'(rd[8:0])) & 255;
        return {(stripe == STRIPES - 1) && (k == BEATS - 1), (k % 64) == 63, (k % 64) == 0, 8'(data)};
    endfunction

    int          beats_total     = 0;
    int          reads_total     = 0;
    int          frame_last_seen = 0;
    logic        held_valid      = 1'b0;
    logic [7:0]  held_data       = 8'd0;
    logic [12:0] cap_r1, cap_r8, cap_r64, cap_r320;

    // Monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clock) begin
        if (nreset) begin
            if (rd_en) begin
                check("read_req", {rd_buffer_select, rd_block_select, rd_addr},
                      model_read(reads_total / BEATS, reads_total % BEATS));
                if (reads_total == 1)   cap_r1   = {rd_buffer_select, rd_block_select, rd_addr};
                if (reads_total == 8)   cap_r8   = {rd_buffer_select, rd_block_select, rd_addr};
                if (reads_total == 64)  cap_r64  = {rd_buffer_select, rd_block_select, rd_addr};
                if (reads_total == 320) cap_r320 = {rd_buffer_select, rd_block_select, rd_addr};
                reads_total++;
            end
            if (held_valid) check("stall_hold", {pix_valid, pix_data}, {1'b1, held_data});
            held_valid = pix_valid && !pix_ready;
            held_data  = pix_data;
            if (pix_valid && pix_ready) begin
                check("beat", {frame_last, mcu_last, mcu_first, pix_data},
                      model_beat(beats_total / BEATS, beats_total % BEATS));
                if (frame_last) frame_last_seen++;
                beats_total++;
            end
        end
    end

    task automatic wait_beats(input int target, input int budget, input bit rnd, input string tag);
        for (int i = 0; i < budget; i++) begin
            @(posedge clock);
            #1;
            if (beats_total >= target) break;
            if (rnd) pix_ready = 1'($urandom_range(0, 1));
        end
        check(tag, beats_total, target);
    endtask

    task automatic start_stripe();
        repeat (4) @(posedge clock);
        #1 frontbuffer_select = ~frontbuffer_select;
    endtask

    int          idle_seen;
    int          n;
    int          m;
    logic [12:0] exp_r1, exp_r8;

    initial begin
        nreset             = 1'b0;
        frontbuffer_select = 1'b1;
        pix_ready          = 1'b1;
`ifdef MCU_READER_TRANSPOSE_EN
        exp_r1 = {1'b0, 3'd0, 9'd8};
        exp_r8 = {1'b0, 3'd0, 9'd1};
`else
        exp_r1 = {1'b0, 3'd0, 9'd1};
        exp_r8 = {1'b0, 3'd0, 9'd8};
`endif

        // Reset state, then release with the select held: no stripe may start.
        repeat (3) @(posedge clock);
        #1 check("reset_outputs",
                 {rd_en, pix_valid, overrun, mcu_first, mcu_last, frame_last,
                  rd_buffer_select, rd_block_select, rd_addr}, 32'd0);
        nreset = 1'b1;
        idle_seen = 0;
        repeat (100) begin
            @(negedge clock);
            if (rd_en || pix_valid) idle_seen++;
        end
        check("idle_no_activity", idle_seen, 0);
        check("idle_overrun", overrun, 0);

        // Re-reset with select=0 so the first stripe is a 0->1 flip.
        @(posedge clock);
        #1 nreset = 1'b0;
        frontbuffer_select = 1'b0;
        repeat (2) @(posedge clock);
        #1 nreset = 1'b1;
        repeat (3) @(posedge clock);
        #1 frontbuffer_select = 1'b1;

        // Stripe 0: latency to first read and first pixel, ready held high.
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clock);
            n++;
            @(negedge clock);
            if (rd_en) break;
        end
        check("latency_rd_en", n, 2);
        m = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clock);
            m++;
            @(negedge clock);
            if (pix_valid) break;
        end
        check("latency_pix_valid", m, 2);
        wait_beats(BEATS, 3000, 1'b0, "stripe0_beats");
        check("read1_addr", cap_r1, exp_r1);
        check("read8_addr", cap_r8, exp_r8);
        check("read64_blk1", cap_r64, {1'b0, 3'd1, 9'd0});
        check("read320_blk0_addr64", cap_r320, {1'b0, 3'd0, 9'd64});
        check("stripe0_overrun", overrun, 0);

        // Stripe 1: random 50% backpressure.
        start_stripe();
        wait_beats(2 * BEATS, 7000, 1'b1, "stripe1_random_ready");
        pix_ready = 1'b1;

        // Stripe 2: stalled, then a second flip mid-stripe -> overrun.
        repeat (4) @(posedge clock);
        #1 pix_ready = 1'b0;
        frontbuffer_select = ~frontbuffer_select;
        repeat (1000) @(posedge clock);
        #1 check("overrun_before_flip", overrun, 0);
        frontbuffer_select = ~frontbuffer_select;
        repeat (3) @(posedge clock);
        #1 check("overrun_set", overrun, 1);
        pix_ready = 1'b1;
        wait_beats(3 * BEATS, 4000, 1'b0, "stripe2_completes");
        wait_beats(4 * BEATS, 3000, 1'b0, "stripe3_auto_half1");

        // Remaining stripes back to back to finish the frame.
        for (int s = 4; s < STRIPES; s++) begin
            start_stripe();
            wait_beats((s + 1) * BEATS, 3000, 1'b0, "stripe_beats");
        end

        repeat (10) @(posedge clock);
        #1;
        check("frame_last_count", frame_last_seen, 1);
        check("total_reads", reads_total, STRIPES * BEATS);
        check("total_beats", beats_total, STRIPES * BEATS);
        check("stripe_counter_wrap", 32'(dut.stripe_q), 0);
        check("overrun_sticky", overrun, 1);
        check("idle_after_frame", {rd_en, pix_valid}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
